stream_cmd_sched: RTL and testbench
===================================

# stream_cmd_sched

Scheduler in front of the shield stream engine. Accepts AXI-style read and write burst requests (address, length, ID) from two independent requesters and arbitrates between them round-robin. Splits each granted burst at page boundaries and issues one page-bounded command per chunk to the stream engine over a valid/ready handshake. It sequences the engine so that no command ever crosses a page.

## Interface
Parameters:
- SHIELD_ADDR_WIDTH, 32, byte address width.
- PAGE_OFFSET_WIDTH, 12, log2 of page size in bytes.
- BEAT_BYTES_LOG, 3, log2 of bytes per burst beat; beats per page = 2^(PAGE_OFFSET_WIDTH-BEAT_BYTES_LOG) = 512.
- ID_WIDTH, 4, transaction ID width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_valid / rd_ready  in / out  1  read request handshake.
- rd_addr  in  SHIELD_ADDR_WIDTH  read start byte address.
- rd_len  in  8  read AXI length (beats - 1).
- rd_id  in  ID_WIDTH  read ID.
- wr_valid / wr_ready / wr_addr / wr_len / wr_id: same as read, for writes.
- cmd_valid / cmd_ready  out / in  1  command handshake to stream engine.
- cmd_addr  out  SHIELD_ADDR_WIDTH  chunk start byte address.
- cmd_burst_count  out  9  beats in this chunk, 1..512.
- cmd_last  out  1  final chunk of the request.
- cmd_is_write  out  1  1 = write request, 0 = read.
- cmd_id  out  ID_WIDTH  ID of the originating request.
- busy  out  1  high whenever state is ISSUE.

## Operation
- State machine with two states, IDLE and ISSUE. Reset state is IDLE.
- IDLE arbitration:
  - If exactly one of rd_valid/wr_valid is high, that requester is granted.
  - If both are high, grant goes to the requester selected by the priority pointer. After reset the pointer selects read.
  - Ready is asserted combinationally to the granted requester only, and only in IDLE.
  - On valid && ready: latch addr, len, id and direction, set cur_addr/cur_len, go to ISSUE, and point the pointer at the other requester.
- Chunk arithmetic, combinational from the current state:
  - beat_off = cur_addr[PAGE_OFFSET_WIDTH-1:BEAT_BYTES_LOG].
  - remaining = 512 - beat_off, 10-bit. A page-aligned address gives 512.
  - need = cur_len + 1, 9-bit.
  - If need <= remaining: count = need, last = 1. Otherwise count = remaining, last = 0.
- ISSUE:
  - cmd_valid = 1, cmd_addr = cur_addr, cmd_burst_count = count, cmd_last = last, plus the latched id and direction.
  - On cmd_ready with last = 1: go to IDLE.
  - On cmd_ready with last = 0: cur_len <= cur_len - count (8-bit), cur_addr <= {cur_addr page bits + 1, PAGE_OFFSET_WIDTH'b0}, stay in ISSUE.
- Page-number increment wraps modulo 2^(SHIELD_ADDR_WIDTH-PAGE_OFFSET_WIDTH) with no error.
- Input addresses are beat-aligned. The low BEAT_BYTES_LOG bits are passed through on the first chunk and ignored in the arithmetic.
- Reset values: cmd_valid = 0, rd_ready = 0, wr_ready = 0, busy = 0, cmd_addr = 0, cmd_burst_count = 0, cmd_last = 0, cmd_is_write = 0, cmd_id = 0, pointer = read.

## Timing
- Request accepted at edge N; cmd_valid high from cycle N+1. Latency is 1 cycle.
- Within one request: one chunk per cycle while cmd_ready is held high.
- Between requests: at least one IDLE cycle; rd_ready and wr_ready are never high in ISSUE.
- While cmd_valid = 1 and cmd_ready = 0, all cmd_* outputs are held stable (AXI rule).
- Asserting rst in any cycle gives IDLE and all reset values at the next edge. An in-flight request is dropped with no further chunks issued.
- Requester inputs are sampled only in the accept cycle. Later changes do not affect an in-flight request.

## Test plan
- Aligned read: addr 0x1000, len 15 -> rd_ready high for 1 cycle; next cycle one cmd with addr 0x1000, count 16, last 1, is_write 0.
- Unaligned split: read addr 0x1FF0, len 7 -> cmd addr 0x1FF0, count 2, last 0; then cmd addr 0x2000, count 6, last 1.
- Max-length split: write addr 0x3F00, len 255 -> cmd 0x3F00, count 32, last 0; then cmd 0x4000, count 224, last 1, is_write 1.
- Arbitration: rd_valid and wr_valid held high from reset, cmd_ready = 1 -> grants alternate read, write, read, write, with one IDLE cycle between each.
- Backpressure: split request with cmd_ready low for 5 cycles on chunk 1 -> cmd_* stable all 5 cycles; no ready to either requester; chunk 2 follows the cycle after cmd_ready rises.
- Reset mid-request: rst pulsed while chunk 1 of the 0x1FF0 case is pending -> next cycle cmd_valid = 0, busy = 0, no chunk 2; pointer back at read.

Source files
------------

// File: rtl/stream_cmd_sched.sv
// rtl/stream_cmd_sched.sv - round-robin read/write burst scheduler that splits bursts at page boundaries
// Issues one page-bounded command per chunk to the stream engine.
module stream_cmd_sched #(
  parameter int SHIELD_ADDR_WIDTH = 32,
  parameter int PAGE_OFFSET_WIDTH = 12,
  parameter int BEAT_BYTES_LOG    = 3,
  parameter int ID_WIDTH          = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_valid,
  output logic                         rd_ready,
  input  logic [SHIELD_ADDR_WIDTH-1:0] rd_addr,
  input  logic [7:0]                   rd_len,
  input  logic [ID_WIDTH-1:0]          rd_id,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [SHIELD_ADDR_WIDTH-1:0] wr_addr,
  input  logic [7:0]                   wr_len,
  input  logic [ID_WIDTH-1:0]          wr_id,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [SHIELD_ADDR_WIDTH-1:0] cmd_addr,
  output logic [8:0]                   cmd_burst_count,
  output logic                         cmd_last,
  output logic                         cmd_is_write,
  output logic [ID_WIDTH-1:0]          cmd_id,
  output logic                         busy
);

  localparam int BW = PAGE_OFFSET_WIDTH - BEAT_BYTES_LOG;
  localparam int PW = SHIELD_ADDR_WIDTH - PAGE_OFFSET_WIDTH;
  localparam logic [BW:0] PAGE_BEATS = {1'b1, {BW{1'b0}}};

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                       state_q, state_d;
  logic                         ptr_q, ptr_d;
  logic [SHIELD_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                   len_q, len_d;
  logic [ID_WIDTH-1:0]          id_q, id_d;
  logic                         wr_q, wr_d;
  logic [8:0]                   count_q, count_d;
  logic                         last_q, last_d;
  logic                         grant_wr;
  logic                         load;

  // Returns {last, count} for a chunk starting at beat offset boff with len+1 beats left.
  function automatic logic [9:0] chunk_f(input logic [BW-1:0] boff, input logic [7:0] len);
    logic [BW:0] remaining;
    logic [8:0]  need;
    remaining = PAGE_BEATS - {1'b0, boff};
    need      = {1'b0, len} + 9'd1;
    if ((BW+1)'(need) <= remaining) chunk_f = {1'b1, need};
    else                            chunk_f = {1'b0, 9'(remaining)};
  endfunction

  assign grant_wr = wr_valid && (!rd_valid || ptr_q);
  assign rd_ready = (state_q == IDLE) && !rst && rd_valid && !grant_wr;
  assign wr_ready = (state_q == IDLE) && !rst && grant_wr;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    wr_d    = wr_q;
    count_d = count_q;
    last_d  = last_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_ready || wr_ready) begin
          addr_d  = grant_wr ? wr_addr : rd_addr;
          len_d   = grant_wr ? wr_len  : rd_len;
          id_d    = grant_wr ? wr_id   : rd_id;
          wr_d    = grant_wr;
          ptr_d   = !grant_wr;
          state_d = ISSUE;
          load    = 1'b1;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            addr_d = {addr_q[SHIELD_ADDR_WIDTH-1:PAGE_OFFSET_WIDTH] + PW'(1),
                      {PAGE_OFFSET_WIDTH{1'b0}}};
            len_d  = len_q - count_q[7:0];
            load   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) {last_d, count_d} = chunk_f(addr_d[PAGE_OFFSET_WIDTH-1:BEAT_BYTES_LOG], len_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      wr_q    <= 1'b0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign cmd_valid       = (state_q == ISSUE);
  assign busy            = (state_q == ISSUE);
  assign cmd_addr        = addr_q;
  assign cmd_burst_count = count_q;
  assign cmd_last        = last_q;
  assign cmd_is_write    = wr_q;
  assign cmd_id          = id_q;

endmodule

// File: tb/tb_stream_cmd_sched.sv
// tb/tb_stream_cmd_sched.sv - directed and randomized check of stream_cmd_sched against a chunk-list model
module tb_stream_cmd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_valid, rd_ready, wr_valid, wr_ready;
  logic [31:0] rd_addr, wr_addr;
  logic [7:0]  rd_len, wr_len;
  logic [3:0]  rd_id, wr_id;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [8:0]  cmd_burst_count;
  logic        cmd_last, cmd_is_write;
  logic [3:0]  cmd_id;
  logic        busy;

  always #5 clk = ~clk;

  stream_cmd_sched dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_len(rd_len), .rd_id(rd_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_len(wr_len), .wr_id(wr_id),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_burst_count(cmd_burst_count), .cmd_last(cmd_last), .cmd_is_write(cmd_is_write),
    .cmd_id(cmd_id), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [8:0]  cnt;
    logic        last;
    logic        wr;
    logic [3:0]  id;
  } chunk_t;

  chunk_t exp_q[$];
  int     ptr_m;
  bit     chk_reset;
  int     vectors = 0;
  int     fails   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-request model: list of page-bounded chunks the engine should see.
  task automatic build(input logic [31:0] addr, input logic [7:0] len,
                       input logic [3:0] id, input logic wr);
    longint a;
    int     left, off, room, c;
    chunk_t e;
    a    = addr;
    left = int'(len) + 1;
    while (left > 0) begin
      off    = int'(a % 4096);
      room   = 512 - off / 8;
      c      = (left < room) ? left : room;
      e.addr = 32'(a);
      e.cnt  = 9'(c);
      e.last = (c == left);
      e.wr   = wr;
      e.id   = id;
      exp_q.push_back(e);
      left -= c;
      a = (((a / 4096) + 1) * 4096) % (64'd1 << 32);
    end
  endtask

  task automatic cycle();
    chunk_t e;
    bit     busy_m;
    int     grant;
    #1;
    busy_m = (exp_q.size() != 0);
    check("busy", 64'(busy), 64'(busy_m));
    check("cmd_valid", 64'(cmd_valid), 64'(busy_m));
    if (busy_m) begin
      e = exp_q[0];
      check("cmd_addr", 64'(cmd_addr), 64'(e.addr));
      check("cmd_burst_count", 64'(cmd_burst_count), 64'(e.cnt));
      check("cmd_last", 64'(cmd_last), 64'(e.last));
      check("cmd_is_write", 64'(cmd_is_write), 64'(e.wr));
      check("cmd_id", 64'(cmd_id), 64'(e.id));
    end
    if (chk_reset) begin
      check("rst_cmd_addr", 64'(cmd_addr), 64'd0);
      check("rst_cmd_count", 64'(cmd_burst_count), 64'd0);
      check("rst_cmd_last", 64'(cmd_last), 64'd0);
      check("rst_cmd_is_write", 64'(cmd_is_write), 64'd0);
      check("rst_cmd_id", 64'(cmd_id), 64'd0);
      chk_reset = 0;
    end
    grant = -1;
    if (!busy_m) begin
      if (rd_valid && wr_valid) grant = ptr_m;
      else if (rd_valid)        grant = 0;
      else if (wr_valid)        grant = 1;
    end
    if (!rst) begin
      check("rd_ready", 64'(rd_ready), 64'(grant == 0));
      check("wr_ready", 64'(wr_ready), 64'(grant == 1));
    end
    if (rst) begin
      exp_q.delete();
      ptr_m     = 0;
      chk_reset = 1;
    end else if (busy_m) begin
      if (cmd_ready) void'(exp_q.pop_front());
    end else if (grant == 0) begin
      build(rd_addr, rd_len, rd_id, 1'b0);
      ptr_m = 1;
    end else if (grant == 1) begin
      build(wr_addr, wr_len, wr_id, 1'b1);
      ptr_m = 0;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a      = $urandom;
    a[2:0] = 3'd0;
    case ($urandom_range(0, 3))
      1:       a[11:0]  = 12'hFF8 - 12'($urandom_range(0, 31) * 8);
      2:       a[31:12] = 20'hFFFFF;
      3:       a[11:0]  = 12'h000;
      default: ;
    endcase
    return a;
  endfunction

  function automatic logic [7:0] rand_len();
    case ($urandom_range(0, 3))
      0:       return 8'd0;
      1:       return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    rd_valid = 1'b0; rd_addr = '0; rd_len = '0; rd_id = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_len = '0; wr_id = '0;
    cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    ptr_m     = 0;
    chk_reset = 1;
    cmd_ready = 1'b1;

    // aligned single-chunk read
    rd_valid = 1'b1; rd_addr = 32'h1000; rd_len = 8'd15; rd_id = 4'd3;
    cycle();
    rd_valid = 1'b0;
    repeat (2) cycle();

    // read split across a page boundary
    rd_valid = 1'b1; rd_addr = 32'h1FF0; rd_len = 8'd7; rd_id = 4'd5;
    cycle();
    rd_valid = 1'b0;
    repeat (3) cycle();

    // maximum-length write split
    wr_valid = 1'b1; wr_addr = 32'h3F00; wr_len = 8'd255; wr_id = 4'd9;
    cycle();
    wr_valid = 1'b0;
    repeat (3) cycle();

    // backpressure on chunk 1 with both requesters waiting
    rd_valid = 1'b1; rd_addr = 32'h1FF0; rd_len = 8'd7; rd_id = 4'd6;
    cmd_ready = 1'b0;
    cycle();
    wr_valid = 1'b1; wr_addr = 32'h8000; wr_len = 8'd1; wr_id = 4'd2;
    rd_addr = 32'h5000; rd_len = 8'd4; rd_id = 4'd1;
    repeat (5) cycle();
    rd_valid = 1'b0; wr_valid = 1'b0; cmd_ready = 1'b1;
    repeat (3) cycle();

    // reset while chunk 1 is pending
    rd_valid = 1'b1; rd_addr = 32'h1FF0; rd_len = 8'd7; rd_id = 4'd7;
    cmd_ready = 1'b0;
    cycle();
    rd_valid = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; cmd_ready = 1'b1;
    repeat (2) cycle();

    // both requesters held: grants must alternate starting with read
    rd_valid = 1'b1; rd_addr = 32'h1000; rd_len = 8'd3; rd_id = 4'd10;
    wr_valid = 1'b1; wr_addr = 32'h2000; wr_len = 8'd3; wr_id = 4'd11;
    repeat (8) cycle();
    rd_valid = 1'b0; wr_valid = 1'b0;
    cycle();

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      rd_valid  = ($urandom_range(0, 2) != 0);
      wr_valid  = ($urandom_range(0, 2) != 0);
      rd_addr   = rand_addr(); rd_len = rand_len(); rd_id = 4'($urandom);
      wr_addr   = rand_addr(); wr_len = rand_len(); wr_id = 4'($urandom);
      cmd_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
